// File: rtl/uart_tx.sv
// uart_tx: byte-wide 8N1/8N2 UART transmitter with a fixed clock divider.
// One character per accepted txen, sent LSB-first; busy covers the whole
// frame, and a request arriving while busy is dropped and latched into ovf.
module uart_tx #(
   parameter int CLKDIV   = 868,
   parameter int STOPBITS = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       txen,
   input  logic [7:0] txdata,
   output logic       busy,
   output logic       tx,
   output logic       ovf
);

   localparam int             DW        = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
   localparam logic [DW-1:0]  DIV_LAST  = DW'(CLKDIV - 1);
   localparam logic           STOP_LAST = 1'(STOPBITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t          state_r,    state_nxt_s;
   logic [DW-1:0]   div_r,      div_nxt_s;
   logic [2:0]      bit_cnt_r,  bit_cnt_nxt_s;
   logic            stop_cnt_r, stop_cnt_nxt_s;
   logic [7:0]      shift_r,    shift_nxt_s;
   logic            tx_r,       tx_nxt_s;
   logic            busy_r,     busy_nxt_s;
   logic            ovf_r,      ovf_nxt_s;
   logic            tick_s;

   // Bit tick: the divider has reached its last count of the bit period.
   always_comb begin
      tick_s = (div_r == DIV_LAST);
   end

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_nxt_s    = state_r;
      div_nxt_s      = div_r;
      bit_cnt_nxt_s  = bit_cnt_r;
      stop_cnt_nxt_s = stop_cnt_r;
      shift_nxt_s    = shift_r;
      tx_nxt_s       = tx_r;
      busy_nxt_s     = busy_r;
      // busy_r is the value seen at this edge, so the falling edge counts too
      ovf_nxt_s      = ovf_r | (txen & busy_r);

      // divider free-runs during a frame and wraps on the tick
      if (state_r != IDLE) begin
         div_nxt_s = tick_s ? {DW{1'b0}} : (div_r + {{(DW-1){1'b0}}, 1'b1});
      end else begin
         div_nxt_s = {DW{1'b0}};
      end

      case (state_r)
         IDLE: begin
            tx_nxt_s   = 1'b1;
            busy_nxt_s = 1'b0;
            if (txen) begin
               shift_nxt_s = txdata;
               tx_nxt_s    = 1'b0;
               busy_nxt_s  = 1'b1;
               div_nxt_s   = {DW{1'b0}};
               state_nxt_s = START;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               tx_nxt_s      = shift_r[0];
               bit_cnt_nxt_s = 3'd0;
               state_nxt_s   = DATA;
            end else begin
               tx_nxt_s = 1'b0;
            end
         end
         DATA: begin
            if (tick_s) begin
               if (bit_cnt_r == 3'd7) begin
                  tx_nxt_s       = 1'b1;
                  stop_cnt_nxt_s = 1'b0;
                  state_nxt_s    = STOP;
               end else begin
                  shift_nxt_s   = {1'b0, shift_r[7:1]};
                  tx_nxt_s      = shift_r[1];
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
               end
            end else begin
               tx_nxt_s = tx_r;
            end
         end
         STOP: begin
            tx_nxt_s = 1'b1;
            if (tick_s) begin
               if (stop_cnt_r == STOP_LAST) begin
                  busy_nxt_s  = 1'b0;
                  state_nxt_s = IDLE;
               end else begin
                  stop_cnt_nxt_s = stop_cnt_r + 1'b1;
               end
            end else begin
               stop_cnt_nxt_s = stop_cnt_r;
            end
         end
         default: begin
            tx_nxt_s    = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, counters and registered outputs; reset aborts any frame at once.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_r    <= IDLE;
         div_r      <= {DW{1'b0}};
         bit_cnt_r  <= 3'd0;
         stop_cnt_r <= 1'b0;
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         div_r      <= div_nxt_s;
         bit_cnt_r  <= bit_cnt_nxt_s;
         stop_cnt_r <= stop_cnt_nxt_s;
         tx_r       <= tx_nxt_s;
         busy_r     <= busy_nxt_s;
         ovf_r      <= ovf_nxt_s;
      end
   end

   // Shift register holds the character; its content is don't-care when idle.
   always_ff @(posedge clk) begin
      shift_r <= shift_nxt_s;
   end

   assign busy = busy_r;
   assign tx   = tx_r;
   assign ovf  = ovf_r;

endmodule
